bat_amateur_mem_arbiter: RTL and testbench

Two-master memory arbiter and access sequencer for the BatAmateur system bus. Shares the single program/data memory between the CPU (master 0) and the program loader/debug port (master 1). Uses round-robin arbitration, a req/ack handshake per master and a fixed-latency memory port. HALT blocks CPU grants so the loader can own memory while the core is stopped.

---
 rtl/bat_amateur_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_bat_amateur_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bat_amateur_mem_arbiter.sv
// rtl/bat_amateur_mem_arbiter.sv - two-master round-robin memory arbiter with fixed-latency memory port
// IDLE picks a winner, ISSUE strobes memory, WAIT counts read latency, DONE pulses ACK.
module bat_amateur_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     HALT,
  input  logic                     M0_REQ,
  input  logic                     M0_WE,
  input  logic [ADDRESS_WIDTH-1:0] M0_ADDR,
  input  logic [DATA_WIDTH-1:0]    M0_WDATA,
  output logic                     M0_GNT,
  output logic                     M0_ACK,
  output logic [DATA_WIDTH-1:0]    M0_RDATA,
  input  logic                     M1_REQ,
  input  logic                     M1_WE,
  input  logic [ADDRESS_WIDTH-1:0] M1_ADDR,
  input  logic [DATA_WIDTH-1:0]    M1_WDATA,
  output logic                     M1_GNT,
  output logic                     M1_ACK,
  output logic [DATA_WIDTH-1:0]    M1_RDATA,
  output logic                     MEM_EN,
  output logic                     MEM_WE,
  output logic [ADDRESS_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0]    MEM_WDATA,
  input  logic [DATA_WIDTH-1:0]    MEM_RDATA,
  output logic                     BUS_IDLE
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY);

  state_t                   state_q, state_d;
  logic                     last_q, last_d;
  logic                     win_q, win_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                     ack0_q, ack0_d, ack1_q, ack1_d;
  logic                     mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                     bus_idle_q, bus_idle_d;
  logic                     elig0, elig1, pick1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      cnt_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      bus_idle_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      bus_idle_q <= bus_idle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    mem_en_d = 1'b0;
    mem_we_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // HALT only masks M0 here, so a granted M0 access always runs to completion.
    elig0    = M0_REQ & ~HALT;
    elig1    = M1_REQ;
    pick1    = elig1 & ~(elig0 & last_q);

    case (state_q)
      S_IDLE: begin
        if (elig0 | elig1) begin
          win_d    = pick1;
          last_d   = pick1;
          gnt0_d   = ~pick1;
          gnt1_d   = pick1;
          mem_en_d = 1'b1;
          mem_we_d = pick1 ? M1_WE    : M0_WE;
          addr_d   = pick1 ? M1_ADDR  : M0_ADDR;
          wdata_d  = pick1 ? M1_WDATA : M0_WDATA;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // mem_we_q is still the winner's write flag during the strobe cycle.
        if (mem_we_q) begin
          ack0_d  = ~win_q;
          ack1_d  = win_q;
          state_d = S_DONE;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (win_q) rdata1_d = MEM_RDATA;
          else       rdata0_d = MEM_RDATA;
          ack0_d  = ~win_q;
          ack1_d  = win_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    bus_idle_d = (state_d == S_IDLE);
  end

  assign M0_GNT    = gnt0_q;
  assign M1_GNT    = gnt1_q;
  assign M0_ACK    = ack0_q;
  assign M1_ACK    = ack1_q;
  assign M0_RDATA  = rdata0_q;
  assign M1_RDATA  = rdata1_q;
  assign MEM_EN    = mem_en_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign BUS_IDLE  = bus_idle_q;

endmodule

// File: tb/tb_bat_amateur_mem_arbiter.sv
// tb/tb_bat_amateur_mem_arbiter.sv - self-checking bench for bat_amateur_mem_arbiter
// Instance 0 (L=2) runs against a transaction-level model; instances 1/2 cover L=1 and L=15.
module tb_bat_amateur_mem_arbiter;

  localparam int NI = 3;
  localparam int L0 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a      [NI];
  logic        halt_a     [NI];
  logic        m0_req_a   [NI];
  logic        m1_req_a   [NI];
  logic        m0_we_a    [NI];
  logic        m1_we_a    [NI];
  logic [15:0] m0_addr_a  [NI];
  logic [15:0] m1_addr_a  [NI];
  logic [15:0] m0_wd_a    [NI];
  logic [15:0] m1_wd_a    [NI];
  logic        m0_gnt_a   [NI];
  logic        m1_gnt_a   [NI];
  logic        m0_ack_a   [NI];
  logic        m1_ack_a   [NI];
  logic [15:0] m0_rd_a    [NI];
  logic [15:0] m1_rd_a    [NI];
  logic        mem_en_a   [NI];
  logic        mem_we_a   [NI];
  logic [15:0] mem_addr_a [NI];
  logic [15:0] mem_wd_a   [NI];
  logic        bus_idle_a [NI];

  int nvec = 0;
  int nerr = 0;

  function automatic logic [15:0] mem_init(input int i);
    return (i == 16) ? 16'hBEEF : (16'(i * 257) ^ 16'h5A3C);
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int L = (k == 0) ? L0 : (k == 1) ? 1 : 15;
    logic [15:0] mem [256];
    logic [15:0] pend = 16'h0;
    int          rcnt = 0;
    logic [15:0] mem_rd;

    initial begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
    end

    // Read data is only valid in the L-th cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
      if (mem_en_a[k] && mem_we_a[k]) mem[mem_addr_a[k][7:0]] <= mem_wd_a[k];
      if (mem_en_a[k] && !mem_we_a[k]) begin
        pend <= mem[mem_addr_a[k][7:0]];
        rcnt <= L;
      end else if (rcnt != 0) begin
        rcnt <= rcnt - 1;
      end
    end
    assign mem_rd = (rcnt == 1) ? pend : 16'hA5A5;

    bat_amateur_mem_arbiter #(
      .ADDRESS_WIDTH(16),
      .DATA_WIDTH   (16),
      .MEM_LATENCY  (L)
    ) u_dut (
      .CLK      (clk),
      .RESET    (rst_a[k]),
      .HALT     (halt_a[k]),
      .M0_REQ   (m0_req_a[k]),
      .M0_WE    (m0_we_a[k]),
      .M0_ADDR  (m0_addr_a[k]),
      .M0_WDATA (m0_wd_a[k]),
      .M0_GNT   (m0_gnt_a[k]),
      .M0_ACK   (m0_ack_a[k]),
      .M0_RDATA (m0_rd_a[k]),
      .M1_REQ   (m1_req_a[k]),
      .M1_WE    (m1_we_a[k]),
      .M1_ADDR  (m1_addr_a[k]),
      .M1_WDATA (m1_wd_a[k]),
      .M1_GNT   (m1_gnt_a[k]),
      .M1_ACK   (m1_ack_a[k]),
      .M1_RDATA (m1_rd_a[k]),
      .MEM_EN   (mem_en_a[k]),
      .MEM_WE   (mem_we_a[k]),
      .MEM_ADDR (mem_addr_a[k]),
      .MEM_WDATA(mem_wd_a[k]),
      .MEM_RDATA(mem_rd),
      .BUS_IDLE (bus_idle_a[k])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, timed from its start cycle.
  logic [15:0] ref_mem [256];
  int          cyc = 0;
  bit          act = 1'b0;
  int          t_s = 0;
  int          t_dur = 0;
  bit          t_w = 1'b0;
  bit          t_we = 1'b0;
  logic [15:0] t_addr = 16'h0;
  logic [15:0] t_wd = 16'h0;
  bit          rr_last = 1'b1;
  logic [15:0] exp_rd [2];
  logic [15:0] exp_addr = 16'h0;
  logic [15:0] exp_wd = 16'h0;
  logic        obs_ack0, obs_ack1, obs_gnt0, obs_gnt1;

  task automatic cycle();
    bit e0, e1, ack_now, en_now;
    @(negedge clk);
    obs_ack0 = m0_ack_a[0];
    obs_ack1 = m1_ack_a[0];
    obs_gnt0 = m0_gnt_a[0];
    obs_gnt1 = m1_gnt_a[0];
    if (!rst_a[0]) begin
      act      = 1'b0;
      rr_last  = 1'b1;
      exp_rd[0] = 16'h0;
      exp_rd[1] = 16'h0;
      exp_addr = 16'h0;
      exp_wd   = 16'h0;
    end
    if (act && cyc >= t_s + t_dur) act = 1'b0;
    ack_now = act && (cyc == t_s + t_dur - 1);
    en_now  = act && (cyc == t_s + 1);
    if (ack_now && !t_we) exp_rd[t_w] = ref_mem[t_addr[7:0]];
    check_eq("m0_gnt",   m0_gnt_a[0],   act && !t_w);
    check_eq("m1_gnt",   m1_gnt_a[0],   act && t_w);
    check_eq("m0_ack",   m0_ack_a[0],   ack_now && !t_w);
    check_eq("m1_ack",   m1_ack_a[0],   ack_now && t_w);
    check_eq("mem_en",   mem_en_a[0],   en_now);
    check_eq("mem_we",   mem_we_a[0],   en_now && t_we);
    check_eq("bus_idle", bus_idle_a[0], !act);
    check_eq("mem_addr", mem_addr_a[0], exp_addr);
    check_eq("mem_wd",   mem_wd_a[0],   exp_wd);
    check_eq("m0_rdata", m0_rd_a[0],    exp_rd[0]);
    check_eq("m1_rdata", m1_rd_a[0],    exp_rd[1]);
    if (rst_a[0] && !act) begin
      e0 = m0_req_a[0] && !halt_a[0];
      e1 = m1_req_a[0];
      if (e0 || e1) begin
        t_w      = (e0 && e1) ? !rr_last : e1;
        rr_last  = t_w;
        t_s      = cyc;
        act      = 1'b1;
        t_we     = t_w ? m1_we_a[0]   : m0_we_a[0];
        t_addr   = t_w ? m1_addr_a[0] : m0_addr_a[0];
        t_wd     = t_w ? m1_wd_a[0]   : m0_wd_a[0];
        exp_addr = t_addr;
        exp_wd   = t_wd;
        t_dur    = t_we ? 3 : L0 + 3;
        if (t_we) ref_mem[t_addr[7:0]] = t_wd;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic req_wait(input bit m, input bit we, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output int gnt_at);
    if (m) begin m1_we_a[0] = we; m1_addr_a[0] = a; m1_wd_a[0] = d; m1_req_a[0] = 1'b1; end
    else   begin m0_we_a[0] = we; m0_addr_a[0] = a; m0_wd_a[0] = d; m0_req_a[0] = 1'b1; end
    lat = -1;
    gnt_at = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      cycle();
      if (gnt_at < 0 && (m ? obs_gnt1 : obs_gnt0)) gnt_at = i;
      if (m ? obs_ack1 : obs_ack0) lat = i;
    end
    if (m) m1_req_a[0] = 1'b0;
    else   m0_req_a[0] = 1'b0;
  endtask

  task automatic lat_test(input int k, input int exp_lat);
    logic [15:0] d;
    int          lat;
    d = 16'($urandom);
    m0_we_a[k] = 1'b1; m0_addr_a[k] = 16'h0040; m0_wd_a[k] = d; m0_req_a[k] = 1'b1;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (m0_ack_a[k]) lat = i;
      @(posedge clk);
      #1;
    end
    check_eq("lat_wr_ack", 32'(lat), 32'd2);
    m0_we_a[k] = 1'b0;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (m0_ack_a[k]) lat = i;
      @(posedge clk);
      #1;
    end
    m0_req_a[k] = 1'b0;
    check_eq("lat_rd_ack", 32'(lat), 32'(exp_lat));
    check_eq("lat_rd_data", m0_rd_a[k], d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, gnt_at, n0, n1, first_g;
    int ackq_m[$];
    int ackq_c[$];
    bit p0, p1;

    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
    exp_rd[0] = 16'h0;
    exp_rd[1] = 16'h0;
    for (int k = 0; k < NI; k++) begin
      rst_a[k] = 1'b0; halt_a[k] = 1'b0;
      m0_req_a[k] = 1'b0; m1_req_a[k] = 1'b0; m0_we_a[k] = 1'b0; m1_we_a[k] = 1'b0;
      m0_addr_a[k] = 16'h0; m1_addr_a[k] = 16'h0; m0_wd_a[k] = 16'h0; m1_wd_a[k] = 16'h0;
    end
    cycle();
    cycle();
    for (int k = 0; k < NI; k++) rst_a[k] = 1'b1;
    cycle();

    // Single read after reset
    req_wait(1'b0, 1'b0, 16'h0010, 16'h0, lat, gnt_at);
    check_eq("rd_ack_cycle", 32'(lat), 32'd4);
    check_eq("rd_gnt_cycle", 32'(gnt_at), 32'd1);
    check_eq("rd_data", m0_rd_a[0], 16'hBEEF);
    check_eq("m1_rd_untouched", m1_rd_a[0], 16'h0);

    // Write then readback from M1
    req_wait(1'b1, 1'b1, 16'h00FF, 16'h1234, lat, gnt_at);
    check_eq("wr_ack_cycle", 32'(lat), 32'd2);
    req_wait(1'b1, 1'b0, 16'h00FF, 16'h0, lat, gnt_at);
    check_eq("rb_ack_cycle", 32'(lat), 32'd4);
    check_eq("rb_data", m1_rd_a[0], 16'h1234);

    // Both masters reading continuously
    m0_we_a[0] = 1'b0; m0_addr_a[0] = 16'h0010; m0_req_a[0] = 1'b1;
    m1_we_a[0] = 1'b0; m1_addr_a[0] = 16'h00FF; m1_req_a[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (obs_ack0) begin ackq_m.push_back(0); ackq_c.push_back(i); end
      if (obs_ack1) begin ackq_m.push_back(1); ackq_c.push_back(i); end
    end
    m0_req_a[0] = 1'b0;
    m1_req_a[0] = 1'b0;
    check_eq("rr_ack_count", 32'(ackq_m.size()), 32'd8);
    for (int i = 0; i < ackq_m.size() && i < 8; i++) begin
      check_eq("rr_order", 32'(ackq_m[i]), 32'(i % 2));
      if (i > 0) check_eq("rr_spacing", 32'(ackq_c[i] - ackq_c[i-1]), 32'(L0 + 3));
    end
    for (int i = 0; i < 6; i++) cycle();

    // HALT keeps M0 off the bus
    halt_a[0] = 1'b1;
    m0_we_a[0] = 1'b1; m0_addr_a[0] = 16'h0020; m0_wd_a[0] = 16'hC0DE; m0_req_a[0] = 1'b1;
    m1_we_a[0] = 1'b1; m1_addr_a[0] = 16'h0021; m1_wd_a[0] = 16'hF00D; m1_req_a[0] = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (obs_ack0) n0++;
      if (obs_ack1) n1++;
    end
    check_eq("halt_no_m0", 32'(n0), 32'd0);
    check_eq("halt_m1_served", 32'(n1), 32'd4);
    halt_a[0] = 1'b0;
    m1_req_a[0] = 1'b0;
    first_g = -1;
    for (int i = 0; i < 10 && first_g < 0; i++) begin
      cycle();
      if (obs_gnt0) first_g = 0;
      else if (obs_gnt1) first_g = 1;
    end
    check_eq("unhalt_m0_first", 32'(first_g), 32'd0);
    m0_req_a[0] = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // HALT raised while M0 read is in WAIT
    m0_we_a[0] = 1'b0; m0_addr_a[0] = 16'h0010; m0_req_a[0] = 1'b1;
    cycle();
    cycle();
    halt_a[0] = 1'b1;
    lat = -1;
    for (int i = 2; i < 40 && lat < 0; i++) begin
      cycle();
      if (obs_ack0) lat = i;
    end
    m0_req_a[0] = 1'b0;
    halt_a[0] = 1'b0;
    check_eq("halt_wait_ack", 32'(lat), 32'd4);
    cycle();

    // Reset in the WAIT cycle of an M0 read
    m0_we_a[0] = 1'b0; m0_addr_a[0] = 16'h0030; m0_req_a[0] = 1'b1;
    cycle();
    cycle();
    rst_a[0] = 1'b0;
    m0_req_a[0] = 1'b0;
    cycle();
    check_eq("rst_bus_idle", bus_idle_a[0], 1'b1);
    check_eq("rst_m0_gnt", m0_gnt_a[0], 1'b0);
    rst_a[0] = 1'b1;
    n0 = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (obs_ack0) n0++;
    end
    check_eq("rst_no_m0_ack", 32'(n0), 32'd0);
    req_wait(1'b1, 1'b0, 16'h0010, 16'h0, lat, gnt_at);
    check_eq("rst_m1_gnt_cycle", 32'(gnt_at), 32'd1);
    check_eq("rst_m1_ack_cycle", 32'(lat), 32'd4);

    // Randomized traffic with HALT toggling and occasional resets
    p0 = 1'b0;
    p1 = 1'b0;
    for (int n = 0; n < 700; n++) begin
      if (!p0 && $urandom_range(3) == 0) begin
        p0 = 1'b1; m0_req_a[0] = 1'b1; m0_we_a[0] = 1'($urandom_range(1));
        m0_addr_a[0] = 16'($urandom_range(31)) | (($urandom_range(7) == 0) ? 16'hAB00 : 16'h0);
        m0_wd_a[0] = 16'($urandom);
      end
      if (!p1 && $urandom_range(3) == 0) begin
        p1 = 1'b1; m1_req_a[0] = 1'b1; m1_we_a[0] = 1'($urandom_range(1));
        m1_addr_a[0] = 16'($urandom_range(31)) | (($urandom_range(7) == 0) ? 16'h3400 : 16'h0);
        m1_wd_a[0] = 16'($urandom);
      end
      if ($urandom_range(29) == 0) halt_a[0] = !halt_a[0];
      if ($urandom_range(199) == 0) begin
        rst_a[0] = 1'b0; p0 = 1'b0; p1 = 1'b0; m0_req_a[0] = 1'b0; m1_req_a[0] = 1'b0;
      end else begin
        rst_a[0] = 1'b1;
      end
      cycle();
      if (obs_ack0) begin
        if ($urandom_range(1) == 0) begin p0 = 1'b0; m0_req_a[0] = 1'b0; end
        else begin m0_we_a[0] = 1'($urandom_range(1)); m0_addr_a[0] = 16'($urandom_range(31)); m0_wd_a[0] = 16'($urandom); end
      end
      if (obs_ack1) begin
        if ($urandom_range(1) == 0) begin p1 = 1'b0; m1_req_a[0] = 1'b0; end
        else begin m1_we_a[0] = 1'($urandom_range(1)); m1_addr_a[0] = 16'($urandom_range(31)); m1_wd_a[0] = 16'($urandom); end
      end
    end
    rst_a[0] = 1'b1;
    halt_a[0] = 1'b0;
    m0_req_a[0] = 1'b0;
    m1_req_a[0] = 1'b0;
    for (int i = 0; i < 20; i++) cycle();

    // Latency extremes
    lat_test(1, 3);
    lat_test(2, 17);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
